// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : fetch-PC owner, req/ack imem sequencer, decode-side FIFO
// Rev 1.0
// ============================================================================
module fetch_controller #(
   parameter int                XLEN      = 32,
   parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
   parameter int                BUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [XLEN-1:0]  imem_rdata,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [XLEN-1:0]  inst_code,
   output logic [XLEN-1:0]  inst_pc
);

   localparam int                PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [PTR_W:0]    c_DEPTH   = (PTR_W+1)'(BUF_DEPTH);
   localparam logic [PTR_W:0]    c_CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]  c_PTR_ONE = PTR_W'(1);
   localparam logic [XLEN-1:0]   c_PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      WAIT_SPACE = 2'd1,
      DISCARD    = 2'd2
   } state_t;

   state_t             r_state, w_state_next;
   logic [XLEN-1:0]    r_fetch_pc, w_fetch_pc_next;
   logic               r_req, w_req_next;
   logic [XLEN-1:0]    r_addr, w_addr_next;
   logic [XLEN-1:0]    r_mem_code [BUF_DEPTH];
   logic [XLEN-1:0]    r_mem_pc   [BUF_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]     r_count, w_count_next;
   logic               w_complete, w_push, w_pop, w_hold;
   logic               w_unused;

   assign w_unused   = ^redirect_pc[1:0];
   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign inst_valid = (r_count != '0);
   assign inst_code  = inst_valid ? r_mem_code[r_rd_ptr] : '0;
   assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : '0;

   always_comb begin
      w_complete      = r_req && imem_ack;
      w_hold          = r_req && !imem_ack;
      w_push          = w_complete && (r_state == FETCH) && !redirect_valid;
      w_pop           = inst_valid && inst_ready && !redirect_valid;
      w_count_next    = r_count;
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_req_next      = r_req;
      w_addr_next     = r_addr;

      if (redirect_valid)
         w_count_next = '0;
      else if (w_push && !w_pop)
         w_count_next = r_count + c_CNT_ONE;
      else if (!w_push && w_pop)
         w_count_next = r_count - c_CNT_ONE;

      if (redirect_valid)
         w_fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_push)
         w_fetch_pc_next = r_fetch_pc + c_PC_STEP;

      // An unacked request is never withdrawn; a redirect only marks its data stale.
      if (w_hold) begin
         if (redirect_valid)
            w_state_next = DISCARD;
      end else if (w_count_next < c_DEPTH) begin
         w_state_next = FETCH;
         w_req_next   = 1'b1;
         w_addr_next  = w_fetch_pc_next;
      end else begin
         w_state_next = WAIT_SPACE;
         w_req_next   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= FETCH;
         r_fetch_pc <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_req      <= w_req_next;
         r_addr     <= w_addr_next;
         r_count    <= w_count_next;
         if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_code[r_wr_ptr] <= imem_rdata;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// tb_fetch_controller : directed scenarios with an in-order delivery scoreboard
// Rev 1.0
// ============================================================================
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;

   logic        ack_tied = 1'b0;
   logic        ack_man = 1'b0;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];

   assign imem_ack   = ack_tied | ack_man;
   assign imem_rdata = imem_addr + 32'h0000_1000;

   always #5 clk = ~clk;

   fetch_controller #(
      .XLEN      (32),
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_code      (inst_code),
      .inst_pc        (inst_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   {31'd0, imem_req},   32'd0);
      check("rst_addr",  imem_addr,           32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_pc",    inst_pc,             32'd0);
      check("rst_code",  inst_code,           32'd0);
      exp_q.delete();
      reset = 1'b1;
   endtask

   // Decode side: every accepted head must match the next expected fetch.
   always @(negedge clk) begin
      logic [31:0] exp_pc;
      if (reset && inst_valid && inst_ready && !redirect_valid) begin
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL deliver_extra: observed pc %h expected no delivery", inst_pc);
         end
         if (exp_q.size() != 0) begin
            exp_pc = exp_q.pop_front();
            check("deliver_pc",   inst_pc,   exp_pc);
            check("deliver_code", inst_code, exp_pc + 32'h0000_1000);
         end
      end
   end

   initial begin
      // Zero-wait streaming
      ack_tied   = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      cyc();
      check("s1_first_req",  {31'd0, imem_req},   32'd1);
      check("s1_first_addr", imem_addr,           32'd0);
      check("s1_valid_c1",   {31'd0, inst_valid}, 32'd0);
      for (int k = 2; k <= 5; k++) begin
         cyc();
         check("s1_valid", {31'd0, inst_valid}, 32'd1);
         check("s1_head",  inst_pc,             32'(4 * (k - 2)));
         check("s1_addr",  imem_addr,           32'(4 * (k - 1)));
      end
      cyc();
      inst_ready = 1'b0;
      check("s1_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure then idle redirect
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      repeat (3) cyc();
      check("s2_req_fall", {31'd0, imem_req},   32'd0);
      check("s2_head0",    inst_pc,             32'h0);
      cyc();
      check("s2_req_held", {31'd0, imem_req},   32'd0);
      inst_ready = 1'b1;
      cyc();
      check("s2_req_resume", {31'd0, imem_req}, 32'd1);
      check("s2_addr_resume", imem_addr,        32'h8);
      check("s2_head1",      inst_pc,           32'h4);
      cyc();
      inst_ready = 1'b0;
      check("s2_head2",   inst_pc,   32'h8);
      check("s2_addr12",  imem_addr, 32'hC);
      repeat (2) cyc();
      check("s2_full_req", {31'd0, imem_req}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      cyc();
      redirect_valid = 1'b0;
      ack_tied       = 1'b0;
      check("s3_flush_valid", {31'd0, inst_valid}, 32'd0);
      check("s3_redir_req",   {31'd0, imem_req},   32'd1);
      check("s3_redir_addr",  imem_addr,           32'h100);
      check("s2_drained", 32'(exp_q.size()), 32'd0);

      // Redirect while a request is in flight, then same-cycle corner and wrap
      inst_ready = 1'b1;
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      cyc();
      ack_man = 1'b1;
      repeat (2) cyc();
      ack_man = 1'b0;
      check("s4_req_at8", imem_addr, 32'h8);
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      cyc();
      redirect_valid = 1'b0;
      check("s4_hold_req",  {31'd0, imem_req}, 32'd1);
      check("s4_hold_addr", imem_addr,         32'h8);
      cyc();
      check("s4_hold_addr2", imem_addr, 32'h8);
      ack_man = 1'b1;
      cyc();
      check("s4_drop_valid", {31'd0, inst_valid}, 32'd0);
      check("s4_new_addr",   imem_addr,           32'h200);
      cyc();
      ack_man = 1'b0;
      cyc();
      ack_man = 1'b1;
      cyc();
      check("s5_one_entry", inst_pc, 32'h204);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      cyc();
      redirect_valid = 1'b0;
      ack_man        = 1'b0;
      check("s5_corner_valid", {31'd0, inst_valid}, 32'd0);
      check("s5_corner_req",   {31'd0, imem_req},   32'd1);
      check("s5_corner_addr",  imem_addr,           32'h300);
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      cyc();
      redirect_valid = 1'b0;
      ack_man        = 1'b1;
      check("s5_discard_addr", imem_addr, 32'h300);
      cyc();
      check("s5_wrap_first", imem_addr, 32'hFFFF_FFFC);
      check("s5_wrap_valid", {31'd0, inst_valid}, 32'd0);
      cyc();
      check("s5_wrap_addr0", imem_addr, 32'h0);
      cyc();
      ack_man = 1'b0;
      cyc();
      check("s5_empty",   {31'd0, inst_valid}, 32'd0);
      check("s5_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset mid-transfer
      inst_ready = 1'b0;
      do_reset();
      cyc();
      ack_man = 1'b1;
      cyc();
      ack_man = 1'b0;
      check("s6_pre_valid", {31'd0, inst_valid}, 32'd1);
      check("s6_pre_req",   {31'd0, imem_req},   32'd1);
      #3;
      reset = 1'b0;
      #1;
      check("s6_async_req",   {31'd0, imem_req},   32'd0);
      check("s6_async_addr",  imem_addr,           32'd0);
      check("s6_async_valid", {31'd0, inst_valid}, 32'd0);
      check("s6_async_pc",    inst_pc,             32'd0);
      check("s6_async_code",  inst_code,           32'd0);
      cyc();
      reset = 1'b1;
      check("s6_rel_req", {31'd0, imem_req}, 32'd0);
      cyc();
      check("s6_restart_req",  {31'd0, imem_req}, 32'd1);
      check("s6_restart_addr", imem_addr,         32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
